// File: rtl/reg_file_wb.sv
// Architectural register file at the MEM/WB boundary: commits writebacks, serves two
// bypassed decode read ports, and tracks outstanding producers for RAW-hazard stalls.
module reg_file_wb #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 3,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              WRegEn_in,
  input  logic [ADDR_W-1:0] WReg1_in,
  input  logic [DATA_W-1:0] WData_in,
  input  logic [ADDR_W-1:0] RReg1,
  input  logic [ADDR_W-1:0] RReg2,
  input  logic              RUse1,
  input  logic              RUse2,
  input  logic              Issue_en,
  input  logic [ADDR_W-1:0] Issue_reg,
  output logic [DATA_W-1:0] RData1,
  output logic [DATA_W-1:0] RData2,
  output logic              Pend1,
  output logic              Pend2,
  output logic              Stall
);

  localparam int N = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [N];
  logic [N-1:0]      pending;
  logic [N-1:0]      set_vec;
  logic [N-1:0]      clr_vec;
  logic              wr_live;
  logic              hit1;
  logic              hit2;
  logic              issue_ok;

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return (R0_ZERO != 0) && (a == '0);
  endfunction

  // Read side: a live writeback to the same index is forwarded, which also resolves its hazard.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    RData1  = '0;
    RData2  = '0;
    wr_live = reset & en & WRegEn_in;
    hit1    = wr_live && (WReg1_in == RReg1);
    hit2    = wr_live && (WReg1_in == RReg2);
    if (reset && !is_r0(RReg1)) RData1 = hit1 ? WData_in : regs[RReg1];
    if (reset && !is_r0(RReg2)) RData2 = hit2 ? WData_in : regs[RReg2];
    Pend1    = reset & pending[RReg1] & ~hit1;
    Pend2    = reset & pending[RReg2] & ~hit2;
    Stall    = (RUse1 & Pend1) | (RUse2 & Pend2);
    issue_ok = Issue_en & ~Stall;
  end

  // Scoreboard update masks; applying set after clear lets the newer producer win.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_ok && !is_r0(Issue_reg)) set_vec[Issue_reg] = 1'b1;
    if (WRegEn_in)                     clr_vec[WReg1_in]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the array is reset because architectural registers must read 0 after reset;
      // this forces flops rather than a RAM macro, which is acceptable at 8 entries.
      for (int i = 0; i < N; i++) regs[i] <= '0;
      pending <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (WRegEn_in && !is_r0(WReg1_in)) regs[WReg1_in] <= WData_in;
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an array-based reference model.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        WRegEn_in;
  logic [2:0]  WReg1_in;
  logic [63:0] WData_in;
  logic [2:0]  RReg1, RReg2;
  logic        RUse1, RUse2;
  logic        Issue_en;
  logic [2:0]  Issue_reg;
  logic [63:0] RData1, RData2;
  logic        Pend1, Pend2, Stall;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_regs [8];
  logic        m_pend [8];

  always #5 clk = ~clk;

  reg_file_wb #(.DATA_W(64), .ADDR_W(3), .R0_ZERO(1)) dut (
    .clk(clk), .reset(reset), .en(en),
    .WRegEn_in(WRegEn_in), .WReg1_in(WReg1_in), .WData_in(WData_in),
    .RReg1(RReg1), .RReg2(RReg2), .RUse1(RUse1), .RUse2(RUse2),
    .Issue_en(Issue_en), .Issue_reg(Issue_reg),
    .RData1(RData1), .RData2(RData2), .Pend1(Pend1), .Pend2(Pend2), .Stall(Stall)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: what a reader must see given stored state and the writeback on the bus now.
  function automatic logic writing_now(input logic [2:0] a);
    return reset && en && WRegEn_in && (WReg1_in == a);
  endfunction

  function automatic logic [63:0] exp_rdata(input logic [2:0] a);
    if (!reset || a == 3'd0) return 64'd0;
    if (writing_now(a))      return WData_in;
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(input logic [2:0] a);
    return reset && m_pend[a] && !writing_now(a);
  endfunction

  function automatic logic exp_stall();
    return (RUse1 && exp_pend(RReg1)) || (RUse2 && exp_pend(RReg2));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = 64'd0;
        m_pend[i] = 1'b0;
      end
    end else if (en) begin
      logic stalled;
      stalled = exp_stall();
      if (WRegEn_in && WReg1_in != 3'd0) m_regs[WReg1_in] = WData_in;
      if (WRegEn_in) m_pend[WReg1_in] = 1'b0;
      if (Issue_en && !stalled && Issue_reg != 3'd0) m_pend[Issue_reg] = 1'b1;
    end
  end

  // Single compare process: every negedge, all outputs against the model.
  always @(negedge clk) begin
    check("rdata1", RData1, exp_rdata(RReg1));
    check("rdata2", RData2, exp_rdata(RReg2));
    check("pend1", 64'(Pend1), 64'(exp_pend(RReg1)));
    check("pend2", 64'(Pend2), 64'(exp_pend(RReg2)));
    check("stall", 64'(Stall), 64'(exp_stall()));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; WRegEn_in = 1'b0; WReg1_in = '0; WData_in = '0;
    RReg1 = '0; RReg2 = '0; RUse1 = 1'b0; RUse2 = 1'b0;
    Issue_en = 1'b0; Issue_reg = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) step();
    check("rst_held_stall", 64'(Stall), 64'd0);
    reset = 1'b1;

    // Reset state on every index, both ports.
    RUse1 = 1'b1; RUse2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      RReg1 = 3'(i); RReg2 = 3'(i);
      #1;
      check("rst_rdata1", RData1, 64'd0);
      check("rst_rdata2", RData2, 64'd0);
      check("rst_pend", 64'(Pend1 | Pend2), 64'd0);
      check("rst_stall", 64'(Stall), 64'd0);
    end
    step();
    idle();

    // Write then read back; writes to r0 are dropped.
    WRegEn_in = 1'b1; WReg1_in = 3'd3; WData_in = 64'hDEADBEEF_00000001;
    step();
    WRegEn_in = 1'b0; RReg1 = 3'd3;
    #1 check("wr_rd_r3", RData1, 64'hDEADBEEF_00000001);
    WRegEn_in = 1'b1; WReg1_in = 3'd0; WData_in = 64'h1234; RReg1 = 3'd0;
    #1 check("r0_bypass_zero", RData1, 64'd0);
    step();
    WRegEn_in = 1'b0;
    #1 check("r0_zero", RData1, 64'd0);

    // Same-cycle bypass, then frozen write with en=0.
    WRegEn_in = 1'b1; WReg1_in = 3'd5; WData_in = 64'h5A; RReg2 = 3'd5;
    #1 check("bypass_r5", RData2, 64'h5A);
    step();
    en = 1'b0; WData_in = 64'h99;
    #1 check("bypass_en0_old", RData2, 64'h5A);
    step();
    en = 1'b1; WRegEn_in = 1'b0;
    #1 check("en0_no_write", RData2, 64'h5A);

    // RAW hazard, ignored issue while stalled, writeback resolves same cycle.
    Issue_en = 1'b1; Issue_reg = 3'd2;
    step();
    Issue_en = 1'b0; RReg1 = 3'd2; RUse1 = 1'b1;
    #1 check("haz_pend1", 64'(Pend1), 64'd1);
    check("haz_stall", 64'(Stall), 64'd1);
    Issue_en = 1'b1; Issue_reg = 3'd4;
    step();
    Issue_en = 1'b0; RReg2 = 3'd4; RUse2 = 1'b0;
    #1 check("stalled_issue_ignored", 64'(Pend2), 64'd0);
    WRegEn_in = 1'b1; WReg1_in = 3'd2; WData_in = 64'h77;
    #1 check("wb_pend1", 64'(Pend1), 64'd0);
    check("wb_stall", 64'(Stall), 64'd0);
    check("wb_rdata1", RData1, 64'h77);
    step();
    WRegEn_in = 1'b0;
    #1 check("after_wb_r2", RData1, 64'h77);
    check("after_wb_pend", 64'(Pend1), 64'd0);
    idle();

    // Simultaneous set and clear on r6: set wins.
    Issue_en = 1'b1; Issue_reg = 3'd6;
    step();
    WRegEn_in = 1'b1; WReg1_in = 3'd6; WData_in = 64'h66;
    step();
    idle();
    RReg2 = 3'd6;
    #1 check("setclr_pend2", 64'(Pend2), 64'd1);
    check("setclr_nouse_stall", 64'(Stall), 64'd0);
    check("setclr_data", RData2, 64'h66);
    RUse2 = 1'b1;
    #1 check("setclr_use_stall", 64'(Stall), 64'd1);
    idle();

    // Reset mid-cycle with a pending bit and a write in flight.
    Issue_en = 1'b1; Issue_reg = 3'd1;
    step();
    Issue_en = 1'b0;
    WRegEn_in = 1'b1; WReg1_in = 3'd1; WData_in = 64'hABC;
    RReg1 = 3'd1; RUse1 = 1'b1; RReg2 = 3'd6; RUse2 = 1'b1;
    #1 check("pre_rst_rdata1", RData1, 64'hABC);
    check("pre_rst_stall", 64'(Stall), 64'd1);
    #1 reset = 1'b0;
    #1 check("mid_rst_rdata1", RData1, 64'd0);
    check("mid_rst_pend", 64'(Pend1 | Pend2), 64'd0);
    check("mid_rst_stall", 64'(Stall), 64'd0);
    step();
    WRegEn_in = 1'b0; reset = 1'b1;
    #1 check("post_rst_r1", RData1, 64'd0);
    check("post_rst_r6_pend", 64'(Pend2), 64'd0);

    // Randomized traffic; narrow index range raises hazard and set/clear collisions.
    for (int c = 0; c < 3000; c++) begin
      step();
      reset     = ($urandom_range(299) != 0);
      en        = ($urandom_range(9) != 0);
      WRegEn_in = $urandom_range(1) == 1;
      WReg1_in  = 3'($urandom_range(7));
      WData_in  = {$urandom, $urandom};
      RReg1     = 3'($urandom_range(7));
      RReg2     = ($urandom_range(3) == 0) ? RReg1 : 3'($urandom_range(7));
      RUse1     = $urandom_range(1) == 1;
      RUse2     = $urandom_range(1) == 1;
      Issue_en  = $urandom_range(1) == 1;
      Issue_reg = 3'($urandom_range(7));
    end
    step();
    reset = 1'b1;
    idle();
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 8-entry x 64-bit architectural register file; the consuming end of the MEM/WB pipeline register.
- Accepts the write-enable, destination and data fields that the MEM/WB register drives, commits them, and supplies two decode-stage read ports with write-through bypass.
- Holds a per-register pending scoreboard: decode marks a destination at issue, writeback clears it. A Stall output lets decode hold on a read-after-write hazard.

Parameters:
DATA_W, 64, register and data width
ADDR_W, 3, register index width; entry count is 2**ADDR_W
R0_ZERO, 1, 1 = register 0 reads as zero, ignores writes and is never pending

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  pipeline enable; 0 freezes all state updates
WRegEn_in  input  1  writeback enable, from MEM/WB WRegEn_out
WReg1_in  input  ADDR_W  writeback destination, from MEM/WB WReg1_out
WData_in  input  DATA_W  writeback data, from MEM/WB Mem_data_out
RReg1  input  ADDR_W  read port 1 index
RReg2  input  ADDR_W  read port 2 index
RUse1  input  1  decode actually consumes port 1
RUse2  input  1  decode actually consumes port 2
Issue_en  input  1  decode issues an instruction that writes Issue_reg
Issue_reg  input  ADDR_W  destination of the issuing instruction
RData1  output  DATA_W  read port 1 data, combinational
RData2  output  DATA_W  read port 2 data, combinational
Pend1  output  1  port 1 source has an outstanding producer
Pend2  output  1  port 2 source has an outstanding producer
Stall  output  1  decode must hold this cycle

Behaviour:
- Reset (reset=0, asynchronous): all registers are 0 and all pending bits are 0. RData=0, Pend=0 and Stall=0 while reset is held. Reset asserted mid-operation discards any in-flight write and pending state immediately.
- Write commit: on posedge clk with en=1 and WRegEn_in=1, regs[WReg1_in] <= WData_in. With R0_ZERO=1, a write to index 0 is dropped. With en=0, no write occurs.
- Read (combinational): RDatak = 0 if R0_ZERO and RRegk==0.
  - Otherwise RDatak = WData_in if en & WRegEn_in & (WReg1_in==RRegk). This bypass has zero latency, so a value written this cycle is visible the same cycle.
  - Otherwise RDatak = regs[RRegk].
- Scoreboard, for each index i, on posedge clk with en=1:
  - Set if issue_ok & Issue_reg==i, where issue_ok = Issue_en & ~Stall.
  - Clear if WRegEn_in & WReg1_in==i.
  - Set and clear on the same index in the same cycle: set wins, because the newer producer is outstanding.
  - Issue_en while Stall=1 is ignored and marks nothing.
  - Index 0 is never set when R0_ZERO=1.
- Pendk = pending[RRegk] & ~(en & WRegEn_in & WReg1_in==RRegk). A same-cycle writeback resolves the hazard through the bypass.
- Stall = (RUse1 & Pend1) | (RUse2 & Pend2). This is combinational. Stall=0 when en=0 and a write is present only if the pending bits are clear; the bypass is gated by en.
- Writeback to a non-pending register is legal: the write commits and the pending bit stays 0.
- Both read ports on the same index return identical data and pending status.
- No wrap-around or overflow conditions exist; indices are full-range decoded.

Test Plan:
- Reset: drive reset=0, then release. Read every index on both ports -> RData=0, Pend=0, Stall=0.
- Write/read: WRegEn_in=1, WReg1_in=3, WData_in=64'hDEADBEEF_00000001, en=1 for one cycle; next cycle RReg1=3 -> RData1=64'hDEADBEEF_00000001. Write to index 0 with R0_ZERO=1 -> RData=0.
- Bypass: in the same cycle as a write of 64'h5A to reg 5, set RReg2=5 -> RData2=64'h5A combinationally. Repeat with en=0 -> RData2 shows the old value and the register is unchanged the next cycle.
- Hazard: Issue_en=1, Issue_reg=2; next cycle RReg1=2, RUse1=1 -> Pend1=1, Stall=1. While stalled, Issue_en=1, Issue_reg=4 -> pending[4] stays 0. Writeback reg 2 with 64'h77 -> Pend1=0 and Stall=0 in that cycle, RData1=64'h77.
- Simultaneous set/clear: pending[6]=1, then in one cycle issue reg 6 and write back reg 6 -> pending[6] remains 1 afterwards. RUse2=0 on reg 6 -> Stall=0 regardless of pending.
- Reset mid-operation: with pending[1]=1 and a write in flight, assert reset between clock edges -> Pend/Stall/RData drop to 0 immediately; after release, reg 1 = 0.
